// File: rtl/fft_frame_sequencer_if.sv
// Stream, RAM-port and control signals of the FFT frame sequencer.
// master: the upstream source / downstream consumer side (testbench, system).
// slave : the sequencer itself.
interface fft_frame_sequencer_if #(
    parameter int BIT_WIDTH  = 11,
    parameter int ADDR_WIDTH = 11,
    parameter int N          = 16
);
    localparam int DW = BIT_WIDTH * N * 2;

    logic                  start;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DW-1:0]         wdata;
    logic [ADDR_WIDTH-1:0] read_address;
    logic                  rd_ready;
    logic                  rd_issue;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  frame_done;

    modport master (
        output start, in_valid, in_data, rd_ready,
        input  busy, in_ready, we, write_address, wdata,
               read_address, rd_issue, rd_valid, rd_last, frame_done
    );

    modport slave (
        input  start, in_valid, in_data, rd_ready,
        output busy, in_ready, we, write_address, wdata,
               read_address, rd_issue, rd_valid, rd_last, frame_done
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// FFT frame sequencer: loads DEPTH = f*N packed rows into the frame RAM in
// arrival order, then sweeps the RAM in 2N-row windows for the compute stage.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start; all strobes low
//   S_LOAD  | in_ready high, each accepted row written at wr_ptr
//   S_GAP   | one spare cycle so the final write lands before any read
//   S_READ  | issue one window base per rd_ready cycle, stride 2N
//   S_FLUSH | all bases issued; wait for the final window's rd_valid
module fft_frame_sequencer #(
    parameter int BIT_WIDTH  = 11,
    parameter int ADDR_WIDTH = 11,
    parameter int f          = 77,
    parameter int N          = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fft_frame_sequencer_if.slave bus
);
    localparam int DW     = BIT_WIDTH * N * 2;
    localparam int DEPTH  = f * N;
    localparam int STRIDE = 2 * N;
    localparam int NUM_RD = (DEPTH + STRIDE - 1) / STRIDE;

    localparam logic [ADDR_WIDTH-1:0] LAST_WR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_RD  = ADDR_WIDTH'((NUM_RD - 1) * STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_READ,
        S_FLUSH
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic                  busy_q;
    logic                  in_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] write_address_q;
    logic [DW-1:0]         wdata_q;
    logic [ADDR_WIDTH-1:0] read_address_q;
    logic                  rd_issue_q;
    logic                  issue_last_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;
    logic                  frame_done_q;

    // Sequencer FSM with every output registered; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            busy_q          <= 1'b0;
            in_ready_q      <= 1'b0;
            we_q            <= 1'b0;
            write_address_q <= '0;
            wdata_q         <= '0;
            read_address_q  <= '0;
            rd_issue_q      <= 1'b0;
            issue_last_q    <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_last_q       <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            rd_issue_q   <= 1'b0;
            frame_done_q <= 1'b0;
            // RAM read is registered, so the window is valid one cycle after issue.
            rd_valid_q   <= rd_issue_q;
            rd_last_q    <= rd_issue_q && issue_last_q;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q      <= S_LOAD;
                        busy_q       <= 1'b1;
                        in_ready_q   <= 1'b1;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        issue_last_q <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        we_q            <= 1'b1;
                        write_address_q <= wr_ptr_q;
                        wdata_q         <= bus.in_data;
                        wr_ptr_q        <= wr_ptr_q + ONE_A;
                        if (wr_ptr_q == LAST_WR) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    state_q <= S_READ;
                end

                S_READ: begin
                    if (bus.rd_ready) begin
                        rd_issue_q     <= 1'b1;
                        read_address_q <= rd_ptr_q;
                        rd_ptr_q       <= rd_ptr_q + STRIDE_A;
                        issue_last_q   <= (rd_ptr_q == LAST_RD);
                        if (rd_ptr_q == LAST_RD) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (rd_valid_q && rd_last_q) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.in_ready      = in_ready_q;
    assign bus.we            = we_q;
    assign bus.write_address = write_address_q;
    assign bus.wdata         = wdata_q;
    assign bus.read_address  = read_address_q;
    assign bus.rd_issue      = rd_issue_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_last       = rd_last_q;
    assign bus.frame_done    = frame_done_q;

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Write/read controller placed directly upstream of the dual-port frame RAM.
- Write side: accepts a frame of f*N packed rows of N complex samples on a valid/ready stream and drives the RAM write port (we, write_address, packed write data) in sequential order.
- Read side: once the frame is fully in memory, sweeps read_address in strides of 2N and flags the cycles in which the RAM's 2N-row data_out window is valid for the downstream compute stage.

Parameters:
- BIT_WIDTH, 11, bits per real or imaginary component.
- ADDR_WIDTH, 11, RAM address width; must satisfy 2^ADDR_WIDTH >= f*N.
- f, 77, rows-per-lane factor; frame depth DEPTH = f*N rows.
- N, 16, complex lanes per row; read stride = 2N rows.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
- busy  out  1  high in every state except IDLE
- in_valid  in  1  input row valid
- in_ready  out  1  sequencer accepts a row this cycle
- in_data  in  BIT_WIDTH*N*2  packed row; lane i real at [(2i+1)*BW-1 : 2i*BW], imag at [(2i+2)*BW-1 : (2i+1)*BW]
- we  out  1  RAM write enable
- write_address  out  ADDR_WIDTH  RAM write address
- wdata  out  BIT_WIDTH*N*2  RAM write data, same packing as in_data
- read_address  out  ADDR_WIDTH  RAM read base address
- rd_ready  in  1  downstream can take a window
- rd_issue  out  1  read_address is a live request this cycle
- rd_valid  out  1  RAM data_out holds the requested 2N-row window
- rd_last  out  1  qualifies rd_valid on the final window
- frame_done  out  1  one-cycle pulse after the final window

Behaviour:
- Reset (rst_n low at posedge, including mid-frame): state IDLE; all outputs 0; internal pointers 0. Any partial frame is abandoned; there is no resume.
- States and transitions:
  - IDLE: transitions to LOAD on start.
  - LOAD: in_ready=1. Transitions to GAP after DEPTH accepted beats.
  - GAP: exactly 1 cycle, so the last write lands before the first read.
  - READ: issues read requests until all are issued, then goes to FLUSH.
  - FLUSH: waits for the last rd_valid, then goes to IDLE.
- Write path: a beat is accepted at cycle t when in_valid && in_ready. At t+1, outputs are registered: we=1, write_address=wr_ptr, wdata=in_data. wr_ptr then increments.
  - Rows are written at addresses 0..DEPTH-1 in arrival order.
  - in_ready drops in the cycle after the DEPTH-th acceptance, so no beat DEPTH+1 is taken.
  - in_valid low inserts bubbles (we=0) without losing position.
- Read path: in READ, a request is issued in a cycle with rd_ready=1. Next cycle: read_address=rd_ptr, rd_issue=1. rd_ptr then increments by 2N.
  - rd_ready low means no new issue; rd_issue=0 and read_address holds.
  - Number of requests R = ceil(DEPTH/(2N)). The last base is (R-1)*2N. Rows beyond DEPTH-1 are zero-padded by the RAM.
  - rd_valid = rd_issue delayed 1 cycle, matching the RAM's registered read.
  - rd_last = 1 together with the rd_valid of the R-th window.
- frame_done: pulses 1 cycle, the cycle after the R-th rd_valid. The state returns to IDLE on the same edge.
- start while busy: ignored, with no effect on counters.
- in_valid outside LOAD: ignored; in_ready=0.
- Pointer arithmetic: ADDR_WIDTH unsigned, no wrap within a frame; both pointers clear on entry to LOAD.
- Throughput:
  - Write: 1 row/cycle.
  - Read: 1 window/cycle.
  - Minimum frame latency: DEPTH + 1 (GAP) + R + 2 cycles from first acceptance to frame_done.

Test Plan:
- Reset then start, with in_valid held 1 and rows carrying value = index (f=77, N=16) -> 1232 writes with we=1, write_address 0..1231, wdata = index; in_ready falls after beat 1232.
- Continue with rd_ready held 1 -> 39 rd_issue cycles, read_address 0, 32, ..., 1216; rd_valid 1 cycle after each; rd_last only on the 39th; frame_done 1 cycle later; busy=0.
- Input bubbles: in_valid toggles every cycle -> exactly 1232 writes, addresses contiguous; no double or lost writes.
- Backpressure: rd_ready low for 5 cycles mid-sweep -> read_address holds, rd_issue=0, no skipped or repeated base.
- rst_n low for 1 cycle midway through LOAD, then a new start -> all outputs 0 after reset; the new frame writes from address 0.
- start pulsed during READ -> ignored; sweep and frame_done unchanged.
